// File: rtl/skid_register_pkg.sv
// rtl/skid_register_pkg.sv - shared types and constants for the two-entry skid register
package skid_register_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/skid_register.sv
// rtl/skid_register.sv - two-entry skid register with registered in_ready/out_valid
// Optional output-transfer counter port xfer_count under macro SKID_REGISTER_STATS_EN.
module skid_register
    import skid_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef SKID_REGISTER_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0] xfer_count
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             in_xfer, out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    state_d = BUSY;
                    main_d  = in_data;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake outputs are flops precomputed from the next state, so in_ready
        // has no combinational path from out_ready.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SKID_REGISTER_STATS_EN
    logic [COUNT_WIDTH-1:0] xfer_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_q <= '0;
        end else if (out_xfer) begin
            xfer_count_q <= xfer_count_q + 1'b1;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule
